branch_resolve_unit: RTL and testbench

Multi-lane successor to the single-lane branch FU. It resolves up to NUM_LANES branches or jumps per cycle and produces link writebacks. It selects the oldest mispredict by ROB age and squashes wrong-path lanes behind a pending redirect. BTB training packets are buffered in a FIFO drained by a ready/valid handshake. It sits between the branch reservation station and the ROB/fetch redirect and BTB.

---
 rtl/branch_resolve_unit_pkg.sv | 61 ++++++
 rtl/branch_resolve_unit_lane.sv | 50 +++++
 rtl/branch_resolve_unit.sv | 190 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared out-of-order pipeline types for branch resolution: RS entries,
// writeback packets, BTB training packets and ROB age helper.
package ooop_types;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ROB_W = 6;
  localparam int unsigned PRF_W = 6;

  typedef logic [XLEN-1:0]  xlen_t;
  typedef logic [ROB_W-1:0] rob_tag_t;
  typedef logic [PRF_W-1:0] prf_tag_t;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  typedef struct packed {
    logic       valid;
    rob_tag_t   rob_tag;
    xlen_t      pc;
    xlen_t      imm;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_branch;
    logic       is_jump;
    logic       predicted_taken;
    xlen_t      predicted_target;
    logic       rd_used;
    prf_tag_t   prd;
  } rs_entry_t;

  typedef struct packed {
    logic     valid;
    rob_tag_t rob_tag;
    logic     rd_used;
    prf_tag_t prd;
    xlen_t    data;
  } wb_pkt_t;

  typedef struct packed {
    xlen_t pc;
    xlen_t target;
    logic  taken;
    logic  is_branch;
  } brq_pkt_t;

  // Distance from the ROB head; smaller means older.
  function automatic rob_tag_t rob_age(input rob_tag_t tag, input rob_tag_t head);
    return tag - head;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_lane.sv
// Combinational resolution of one branch/jump lane: direction, target,
// misprediction and redirect PC.
module branch_lane_resolve
  import ooop_types::*;
(
  input  rs_entry_t entry_i,
  input  xlen_t     src1_i,
  input  xlen_t     src2_i,
  output logic      is_ctrl_o,
  output logic      is_branch_o,
  output logic      is_jump_o,
  output logic      taken_o,
  output xlen_t     target_o,
  output xlen_t     link_o,
  output xlen_t     redirect_pc_o,
  output logic      mispredict_o
);

  logic  is_jalr;
  logic  cond;
  xlen_t jalr_sum;

  always_comb begin
    is_jalr     = (entry_i.opcode == OPC_JALR);
    is_jump_o   = entry_i.is_jump || (entry_i.opcode == OPC_JAL) || is_jalr;
    is_branch_o = !is_jump_o && (entry_i.is_branch || (entry_i.opcode == OPC_BRANCH));
    is_ctrl_o   = is_jump_o || is_branch_o;

    case (br_funct3_e'(entry_i.funct3))
      F3_BEQ:  cond = (src1_i == src2_i);
      F3_BNE:  cond = (src1_i != src2_i);
      F3_BLT:  cond = ($signed(src1_i) <  $signed(src2_i));
      F3_BGE:  cond = ($signed(src1_i) >= $signed(src2_i));
      F3_BLTU: cond = (src1_i <  src2_i);
      F3_BGEU: cond = (src1_i >= src2_i);
      default: cond = 1'b0;
    endcase

    jalr_sum      = src1_i + entry_i.imm;
    target_o      = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : entry_i.pc + entry_i.imm;
    link_o        = entry_i.pc + 32'd4;
    taken_o       = is_jump_o || (is_branch_o && cond);
    redirect_pc_o = taken_o ? target_o : link_o;

    mispredict_o  = is_ctrl_o &&
                    ((entry_i.predicted_taken != taken_o) ||
                     (taken_o && (entry_i.predicted_target != target_o)));
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Multi-lane branch resolve: per-lane writeback, oldest-mispredict redirect,
// wrong-path lane squash and a multi-push BTB training FIFO.
module branch_resolve_unit
  import ooop_types::*;
#(
  parameter int unsigned NUM_LANES  = 2,
  parameter int unsigned BTBQ_DEPTH = 4,
  parameter int unsigned DROP_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic [ROB_W-1:0]              rob_head_i,
  input  logic [NUM_LANES-1:0]          issue_valid_i,
  input  rs_entry_t                     entry_i [NUM_LANES],
  input  xlen_t                         src1_i  [NUM_LANES],
  input  xlen_t                         src2_i  [NUM_LANES],
  output wb_pkt_t                       wb_o    [NUM_LANES],
  output logic                          mispredict_o,
  output logic [31:0]                   target_pc_o,
  output logic [ROB_W-1:0]              recover_tag_o,
  output logic                          btb_update_valid_o,
  input  logic                          btb_update_ready_i,
  output logic [31:0]                   btb_update_pc_o,
  output logic [31:0]                   btb_update_target_o,
  output logic                          btb_update_taken_o,
  output logic                          btb_update_is_branch_o,
  output logic [$clog2(BTBQ_DEPTH):0]   btbq_count_o,
  output logic [DROP_W-1:0]             btb_drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(BTBQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [NUM_LANES-1:0] ln_ctrl, ln_br, ln_jump, ln_taken, ln_mp;
  xlen_t                ln_tgt   [NUM_LANES];
  xlen_t                ln_link  [NUM_LANES];
  xlen_t                ln_redir [NUM_LANES];

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    branch_lane_resolve u_lane (
      .entry_i       (entry_i[k]),
      .src1_i        (src1_i[k]),
      .src2_i        (src2_i[k]),
      .is_ctrl_o     (ln_ctrl[k]),
      .is_branch_o   (ln_br[k]),
      .is_jump_o     (ln_jump[k]),
      .taken_o       (ln_taken[k]),
      .target_o      (ln_tgt[k]),
      .link_o        (ln_link[k]),
      .redirect_pc_o (ln_redir[k]),
      .mispredict_o  (ln_mp[k])
    );
  end

  // Lanes younger than the redirect just issued are on the wrong path.
  logic [NUM_LANES-1:0] killed, live;
  rob_tag_t             rec_age;

  always_comb begin
    rec_age = rob_age(recover_tag_o, rob_head_i);
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      killed[k] = mispredict_o && (rob_age(entry_i[k].rob_tag, rob_head_i) > rec_age);
      live[k]   = issue_valid_i[k] && entry_i[k].valid && !killed[k];
    end
  end

  logic     sel_valid;
  rob_tag_t sel_age, sel_tag;
  xlen_t    sel_pc;

  always_comb begin
    sel_valid = 1'b0;
    sel_age   = '1;
    sel_tag   = '0;
    sel_pc    = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (live[k] && ln_mp[k] &&
          (!sel_valid || (rob_age(entry_i[k].rob_tag, rob_head_i) < sel_age))) begin
        sel_valid = 1'b1;
        sel_age   = rob_age(entry_i[k].rob_tag, rob_head_i);
        sel_tag   = entry_i[k].rob_tag;
        sel_pc    = ln_redir[k];
      end
    end
  end

  wb_pkt_t  wb_d [NUM_LANES];
  brq_pkt_t pkt  [NUM_LANES];

  always_comb begin
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      wb_d[k] = '0;
      if (live[k]) begin
        wb_d[k].valid   = 1'b1;
        wb_d[k].rob_tag = entry_i[k].rob_tag;
        wb_d[k].rd_used = entry_i[k].rd_used;
        wb_d[k].prd     = entry_i[k].rd_used ? entry_i[k].prd : '0;
        wb_d[k].data    = (ln_jump[k] && entry_i[k].rd_used) ? ln_link[k] : '0;
      end
      pkt[k].pc        = entry_i[k].pc;
      pkt[k].target    = ln_tgt[k];
      pkt[k].taken     = ln_taken[k];
      pkt[k].is_branch = ln_br[k];
    end
  end

  brq_pkt_t         mem [BTBQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic [CNT_W-1:0] free_slots, n_push, n_drop;
  logic [NUM_LANES-1:0] push_en;
  logic [PTR_W-1:0] push_slot [NUM_LANES];
  logic [DROP_W:0]  drop_sum;
  logic [DROP_W-1:0] drop_nxt;

  // Pushes are packed into consecutive slots in lane order; a pop this
  // cycle frees its slot for a same-cycle push.
  always_comb begin
    pop        = (count != '0) && btb_update_ready_i;
    free_slots = CNT_W'(BTBQ_DEPTH) - count + CNT_W'(pop);
    n_push     = '0;
    n_drop     = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      push_en[k]   = 1'b0;
      push_slot[k] = wr_ptr + n_push[PTR_W-1:0];
      if (live[k] && ln_ctrl[k] && !flush_i) begin
        if (n_push < free_slots) begin
          push_en[k] = 1'b1;
          n_push     = n_push + CNT_W'(1);
        end else begin
          n_drop     = n_drop + CNT_W'(1);
        end
      end
    end
    drop_sum = {1'b0, btb_drop_cnt_o} + (DROP_W+1)'(n_drop);
    drop_nxt = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      btb_drop_cnt_o <= '0;
      mispredict_o   <= 1'b0;
      target_pc_o    <= '0;
      recover_tag_o  <= '0;
      for (int unsigned k = 0; k < NUM_LANES; k++) wb_o[k] <= '0;
    end else begin
      wr_ptr         <= wr_ptr + n_push[PTR_W-1:0];
      rd_ptr         <= rd_ptr + PTR_W'(pop);
      count          <= count + n_push - CNT_W'(pop);
      btb_drop_cnt_o <= drop_nxt;
      if (flush_i) begin
        mispredict_o  <= 1'b0;
        target_pc_o   <= '0;
        recover_tag_o <= '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) wb_o[k] <= '0;
      end else begin
        mispredict_o <= sel_valid;
        if (sel_valid) begin
          target_pc_o   <= sel_pc;
          recover_tag_o <= sel_tag;
        end
        for (int unsigned k = 0; k < NUM_LANES; k++) wb_o[k] <= wb_d[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (push_en[k]) mem[push_slot[k]] <= pkt[k];
    end
  end

  brq_pkt_t head;

  always_comb begin
    head                   = mem[rd_ptr];
    btb_update_valid_o     = (count != '0);
    btb_update_pc_o        = btb_update_valid_o ? head.pc        : '0;
    btb_update_target_o    = btb_update_valid_o ? head.target    : '0;
    btb_update_taken_o     = btb_update_valid_o && head.taken;
    btb_update_is_branch_o = btb_update_valid_o && head.is_branch;
    btbq_count_o           = count;
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: single-cycle vector table plus
// hand-written squash, FIFO overflow, reset and flush sequences.
module tb_branch_resolve_unit;
  import ooop_types::*;

  logic        clk = 1'b0;
  logic        rst, flush, ready;
  logic [5:0]  head;
  logic [1:0]  iv;
  rs_entry_t   ent [2];
  xlen_t       s1 [2];
  xlen_t       s2 [2];
  wb_pkt_t     wb [2];
  logic        mp, bv, btaken, bisbr;
  logic [31:0] tgt, bpc, btgt;
  logic [5:0]  rtag;
  logic [2:0]  cnt;
  logic [15:0] drop;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.NUM_LANES(2), .BTBQ_DEPTH(4), .DROP_W(16)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .rob_head_i(head),
    .issue_valid_i(iv), .entry_i(ent), .src1_i(s1), .src2_i(s2),
    .wb_o(wb), .mispredict_o(mp), .target_pc_o(tgt), .recover_tag_o(rtag),
    .btb_update_valid_o(bv), .btb_update_ready_i(ready),
    .btb_update_pc_o(bpc), .btb_update_target_o(btgt),
    .btb_update_taken_o(btaken), .btb_update_is_branch_o(bisbr),
    .btbq_count_o(cnt), .btb_drop_cnt_o(drop)
  );

  typedef struct {
    logic [1:0]  iv;
    logic [5:0]  head;
    rs_entry_t   e0;
    logic [31:0] a0, b0;
    rs_entry_t   e1;
    logic [31:0] a1, b1;
    logic        mp;
    logic [31:0] tgt;
    logic [5:0]  tag;
    logic        v0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] d1;
  } vec_t;

  vec_t vt [8];

  function automatic rs_entry_t mk(input logic [5:0] tag, input logic [31:0] pc,
                                   input logic [31:0] imm, input logic [6:0] opc,
                                   input logic [2:0] f3, input logic pt,
                                   input logic [31:0] ptgt, input logic rdu,
                                   input logic [5:0] prd);
    rs_entry_t e;
    e = '0;
    e.valid = 1'b1;  e.rob_tag = tag;  e.pc = pc;  e.imm = imm;
    e.opcode = opc;  e.funct3 = f3;    e.predicted_taken = pt;
    e.predicted_target = ptgt;  e.rd_used = rdu;  e.prd = prd;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input rs_entry_t e0, input logic [31:0] a0,
                       input logic [31:0] b0, input rs_entry_t e1,
                       input logic [31:0] a1, input logic [31:0] b1);
    iv = v; ent[0] = e0; ent[1] = e1;
    s1[0] = a0; s2[0] = b0; s1[1] = a1; s2[1] = b1;
  endtask

  task automatic idle();
    iv = 2'b00; ent[0] = '0; ent[1] = '0;
    s1[0] = '0; s2[0] = '0; s1[1] = '0; s2[1] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Branch with a known-correct not-taken prediction (src1 != src2 under BEQ).
  function automatic rs_entry_t nt_br(input logic [5:0] tag, input logic [31:0] pc);
    return mk(tag, pc, 32'h8, OPC_BRANCH, 3'b000, 1'b0, 32'h0, 1'b0, 6'd0);
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; ready = 1'b1; head = '0;
    idle();

    vt[0] = '{2'b01, 6'd0, mk(6'd3, 32'h100, 32'h20, OPC_BRANCH, 3'b000, 1'b0, 32'h0, 1'b0, 6'd0),
              32'd5, 32'd5, '0, 32'd0, 32'd0,
              1'b1, 32'h120, 6'd3, 1'b1, 32'h0, 1'b0, 32'h0};
    vt[1] = '{2'b11, 6'd6, mk(6'd9, 32'h200, 32'h40, OPC_BRANCH, 3'b001, 1'b0, 32'h0, 1'b0, 6'd0),
              32'd1, 32'd2, mk(6'd7, 32'h300, 32'h100, OPC_JAL, 3'b000, 1'b0, 32'h0, 1'b0, 6'd0),
              32'd0, 32'd0,
              1'b1, 32'h400, 6'd7, 1'b1, 32'h0, 1'b1, 32'h0};
    vt[2] = vt[1];
    vt[2].head = 6'd8; vt[2].tgt = 32'h240; vt[2].tag = 6'd9;
    vt[3] = '{2'b01, 6'd0, mk(6'd10, 32'h500, 32'h4, OPC_JALR, 3'b000, 1'b1, 32'h1006, 1'b1, 6'd12),
              32'h1003, 32'd0, '0, 32'd0, 32'd0,
              1'b0, 32'h0, 6'd0, 1'b1, 32'h504, 1'b0, 32'h0};
    vt[4] = '{2'b11, 6'd0, mk(6'd12, 32'h700, 32'hFFFF_FFF0, OPC_BRANCH, 3'b100, 1'b1, 32'h6F0, 1'b0, 6'd0),
              32'hFFFF_FFFF, 32'd1,
              mk(6'd11, 32'h600, 32'h40, OPC_BRANCH, 3'b110, 1'b1, 32'h640, 1'b0, 6'd0),
              32'hFFFF_FFFF, 32'd1,
              1'b1, 32'h604, 6'd11, 1'b1, 32'h0, 1'b1, 32'h0};
    vt[5] = '{2'b11, 6'd0, mk(6'd20, 32'h800, 32'h8, OPC_BRANCH, 3'b101, 1'b1, 32'h999, 1'b0, 6'd0),
              32'd5, 32'd5, mk(6'd21, 32'h900, 32'h8, OPC_BRANCH, 3'b111, 1'b0, 32'h0, 1'b0, 6'd0),
              32'd3, 32'd4,
              1'b1, 32'h808, 6'd20, 1'b1, 32'h0, 1'b1, 32'h0};
    vt[6] = '{2'b11, 6'd0, mk(6'd22, 32'hA00, 32'h8, OPC_BRANCH, 3'b010, 1'b0, 32'h0, 1'b0, 6'd0),
              32'd0, 32'd0, mk(6'd23, 32'hB00, 32'h8, OPC_JAL, 3'b000, 1'b0, 32'h0, 1'b1, 6'd3),
              32'd0, 32'd0,
              1'b0, 32'h0, 6'd0, 1'b1, 32'h0, 1'b0, 32'h0};
    vt[6].e1.valid = 1'b0;
    vt[7] = '{2'b11, 6'd0, mk(6'd24, 32'hFFFF_FFF0, 32'h20, 7'h00, 3'b000, 1'b1, 32'h10, 1'b1, 6'd5),
              32'd0, 32'd0, mk(6'd25, 32'h40, 32'h10, OPC_BRANCH, 3'b000, 1'b1, 32'h50, 1'b0, 6'd0),
              32'd1, 32'd2,
              1'b1, 32'h44, 6'd25, 1'b1, 32'hFFFF_FFF4, 1'b1, 32'h0};
    vt[7].e0.is_jump = 1'b1;

    tick(); tick();
    rst = 1'b0;
    chk("rst_mp", 32'(mp), 32'd0);
    chk("rst_wb0", 32'(wb[0].valid), 32'd0);
    chk("rst_tgt", tgt, 32'h0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_bv", 32'(bv), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);

    for (int i = 0; i < 8; i++) begin
      head = vt[i].head;
      drive(vt[i].iv, vt[i].e0, vt[i].a0, vt[i].b0, vt[i].e1, vt[i].a1, vt[i].b1);
      tick();
      chk($sformatf("v%0d_mp", i), 32'(mp), 32'(vt[i].mp));
      if (vt[i].mp) begin
        chk($sformatf("v%0d_tgt", i), tgt, vt[i].tgt);
        chk($sformatf("v%0d_tag", i), 32'(rtag), 32'(vt[i].tag));
      end
      chk($sformatf("v%0d_wb0v", i), 32'(wb[0].valid), 32'(vt[i].v0));
      chk($sformatf("v%0d_wb0d", i), wb[0].data, vt[i].d0);
      chk($sformatf("v%0d_wb1v", i), 32'(wb[1].valid), 32'(vt[i].v1));
      chk($sformatf("v%0d_wb1d", i), wb[1].data, vt[i].d1);
      idle();
      tick();
    end
    chk("jalr_prd", 32'(vt[3].e0.prd), 32'd12);
    for (int i = 0; i < 6; i++) tick();
    chk("drain_cnt", 32'(cnt), 32'd0);

    // Wrong-path squash behind a pending redirect.
    ready = 1'b0; head = 6'd0;
    drive(2'b01, mk(6'd3, 32'h100, 32'h20, OPC_BRANCH, 3'b000, 1'b0, 32'h0, 1'b0, 6'd0),
          32'd5, 32'd5, '0, 32'd0, 32'd0);
    tick();
    chk("kill_mp", 32'(mp), 32'd1);
    chk("kill_tag", 32'(rtag), 32'd3);
    drive(2'b11, nt_br(6'd5, 32'h140), 32'd1, 32'd2, nt_br(6'd2, 32'h180), 32'd1, 32'd2);
    tick();
    idle();
    chk("kill_wb0", 32'(wb[0].valid), 32'd0);
    chk("kill_wb1", 32'(wb[1].valid), 32'd1);
    chk("kill_wb1tag", 32'(wb[1].rob_tag), 32'd2);
    chk("kill_cnt", 32'(cnt), 32'd2);
    chk("kill_head0", bpc, 32'h100);
    chk("kill_head0_tgt", btgt, 32'h120);
    chk("kill_head0_tk", 32'(btaken), 32'd1);
    ready = 1'b1;
    tick();
    chk("kill_head1", bpc, 32'h180);
    tick();
    chk("kill_empty", 32'(bv), 32'd0);

    // Overflow with a stalled consumer, then push+pop at full.
    ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, nt_br(6'(2 * c), 32'h1000 + 32'(c) * 32'h20), 32'd1, 32'd2,
            nt_br(6'(2 * c + 1), 32'h1010 + 32'(c) * 32'h20), 32'd1, 32'd2);
      tick();
    end
    chk("ovf_cnt", 32'(cnt), 32'd4);
    chk("ovf_drop", 32'(drop), 32'd2);
    ready = 1'b1;
    drive(2'b11, nt_br(6'd10, 32'h1060), 32'd1, 32'd2, nt_br(6'd11, 32'h1070), 32'd1, 32'd2);
    tick();
    idle();
    chk("full_pp_cnt", 32'(cnt), 32'd4);
    chk("full_pp_drop", 32'(drop), 32'd3);
    chk("full_pp_isbr", 32'(bisbr), 32'd1);
    chk("full_pp_taken", 32'(btaken), 32'd0);
    for (int j = 0; j < 4; j++) begin
      logic [31:0] exp_pc;
      exp_pc = (j < 3) ? 32'h1010 + 32'(j) * 32'h10 : 32'h1060;
      chk($sformatf("order%0d_v", j), 32'(bv), 32'd1);
      chk($sformatf("order%0d_pc", j), bpc, exp_pc);
      tick();
    end
    chk("order_empty", 32'(bv), 32'd0);
    chk("order_cnt", 32'(cnt), 32'd0);

    // Synchronous reset with three queued entries and a redirect pending.
    ready = 1'b0;
    drive(2'b11, nt_br(6'd30, 32'h2000), 32'd1, 32'd2, nt_br(6'd31, 32'h2010), 32'd1, 32'd2);
    tick();
    drive(2'b01, mk(6'd40, 32'h2020, 32'h10, OPC_BRANCH, 3'b000, 1'b0, 32'h0, 1'b0, 6'd0),
          32'd7, 32'd7, '0, 32'd0, 32'd0);
    tick();
    idle();
    chk("pre_rst_cnt", 32'(cnt), 32'd3);
    chk("pre_rst_mp", 32'(mp), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_cnt", 32'(cnt), 32'd0);
    chk("mid_rst_bv", 32'(bv), 32'd0);
    chk("mid_rst_mp", 32'(mp), 32'd0);
    chk("mid_rst_drop", 32'(drop), 32'd0);

    // Flush keeps queued entries, clears results and blocks new pushes.
    drive(2'b11, mk(6'd1, 32'h3000, 32'h40, OPC_BRANCH, 3'b000, 1'b0, 32'h0, 1'b0, 6'd0),
          32'd9, 32'd9, nt_br(6'd2, 32'h3010), 32'd1, 32'd2);
    tick();
    chk("pre_fl_cnt", 32'(cnt), 32'd2);
    chk("pre_fl_mp", 32'(mp), 32'd1);
    chk("pre_fl_tgt", tgt, 32'h3040);
    flush = 1'b1;
    drive(2'b01, nt_br(6'd0, 32'h3100), 32'd1, 32'd2, '0, 32'd0, 32'd0);
    tick();
    flush = 1'b0;
    idle();
    chk("fl_cnt", 32'(cnt), 32'd2);
    chk("fl_wb0", 32'(wb[0].valid), 32'd0);
    chk("fl_wb1", 32'(wb[1].valid), 32'd0);
    chk("fl_mp", 32'(mp), 32'd0);
    chk("fl_tgt", tgt, 32'h0);
    ready = 1'b1;
    chk("fl_head0", bpc, 32'h3000);
    tick();
    chk("fl_head1", bpc, 32'h3010);
    tick();
    chk("fl_empty", 32'(bv), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
